// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: synchronizer, debounce counter, edge pulses.
// Optional per-channel press-toggle state is built only when BTN_TOGGLE_EN is defined.
module btn_conditioner #(
  parameter int FREQ        = 12000000,
  parameter int DEBOUNCE_MS = 10,
  parameter int WIDTH       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] toggle
);

  localparam int RAW_CYCLES = (FREQ / 1000) * DEBOUNCE_MS;
  localparam int DEB_CYCLES = (RAW_CYCLES < 1) ? 1 : RAW_CYCLES;
  localparam int CNT_W      = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  for (genvar ch = 0; ch < WIDTH; ch++) begin : g_chan
    logic             sync_meta;
    logic             sync_stable;
    logic [CNT_W-1:0] count;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             expire;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_meta   <= 1'b0;
        sync_stable <= 1'b0;
      end else begin
        sync_meta   <= btn[ch];
        sync_stable <= sync_meta;
      end
    end

    // Input has disagreed with the debounced level for the full window on this edge.
    assign expire = (sync_stable != level_q) && (count == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= expire & ~level_q;
        release_q <= expire &  level_q;
        if (sync_stable == level_q) begin
          count <= '0;
        end else if (expire) begin
          count   <= '0;
          level_q <= ~level_q;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end

    assign level[ch]         = level_q;
    assign press_pulse[ch]   = press_q;
    assign release_pulse[ch] = release_q;

`ifdef BTN_TOGGLE_EN
    logic toggle_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        toggle_q <= 1'b0;
      end else if (expire && !level_q) begin
        toggle_q <= ~toggle_q;
      end
    end

    assign toggle[ch] = toggle_q;
`else
    assign toggle[ch] = 1'b0;
`endif
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter FREQ, default 12000000, CLK frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 10, required stable time in milliseconds.
REQ-003 Parameter WIDTH, default 2, number of independent button channels.
REQ-004 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 RS_N  input  1  asynchronous active-low reset.
REQ-006 BTN  input  WIDTH  raw asynchronous button levels, active-high.
REQ-007 LEVEL  output  WIDTH  debounced button level per channel.
REQ-008 PRESS  output  WIDTH  one-cycle pulse on each debounced 0->1 transition.
REQ-009 RELEASE  output  WIDTH  one-cycle pulse on each debounced 1->0 transition.
REQ-010 TOGGLE  output  WIDTH  per-channel state that flips on each press; intended to drive a downstream count-enable.

Function
REQ-011 Each channel SHALL be fully independent: 2-flop synchronizer, debounce counter, and output registers.
REQ-012 DEB_CYCLES SHALL equal (FREQ/1000)*DEBOUNCE_MS, clamped to a minimum of 1.
REQ-013 The counter width SHALL be clog2(DEB_CYCLES)+1 bits.
REQ-014 When the synchronized input equals LEVEL, the channel counter SHALL clear to 0.
REQ-015 When the synchronized input differs from LEVEL and counter < DEB_CYCLES-1, the counter SHALL increment by 1.
REQ-016 When the synchronized input differs from LEVEL and counter = DEB_CYCLES-1, LEVEL SHALL flip and the counter SHALL clear, all on the same edge.
REQ-017 Latency: a clean BTN change held steady SHALL appear on LEVEL at the (DEB_CYCLES+2)th rising CLK edge after the change.
REQ-018 Any BTN excursion shorter than DEB_CYCLES synchronized cycles SHALL leave LEVEL, PRESS, RELEASE and TOGGLE unchanged.
REQ-019 PRESS SHALL be registered and high for exactly the one cycle that begins at the edge where LEVEL goes 0->1.
REQ-020 RELEASE SHALL be registered and high for exactly the one cycle that begins at the edge where LEVEL goes 1->0.
REQ-021 PRESS and RELEASE SHALL never be high together on the same channel.
REQ-022 TOGGLE SHALL flip on the same edge at which PRESS asserts, and SHALL not change on release.
REQ-023 Simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-024 RS_N low SHALL asynchronously clear the synchronizers, counters, LEVEL, PRESS, RELEASE and TOGGLE to 0.
REQ-025 After RS_N deasserts with BTN held high, LEVEL SHALL rise at edge DEB_CYCLES+2 counted from the first post-reset edge, with a PRESS pulse.
REQ-026 Reset asserted mid-count SHALL discard the partial count.

Configuration
REQ-027 Macro BTN_TOGGLE_EN defined: TOGGLE registers are built and behave per REQ-022.
REQ-028 Macro BTN_TOGGLE_EN undefined: no toggle registers are built, and TOGGLE is driven constant 0.

Verification (FREQ=1000, DEBOUNCE_MS=4, so DEB_CYCLES=4; WIDTH=2; BTN_TOGGLE_EN defined unless stated)
REQ-029 Clean press: BTN[0] 0->1, held 20 cycles -> LEVEL[0] rises at edge 6; PRESS[0] high 1 cycle; TOGGLE[0]=1; channel 1 all 0.
REQ-030 Bounce: BTN[0] high for 3 cycles, low for 2, high for 3, then low -> LEVEL, PRESS, RELEASE and TOGGLE stay 0 throughout.
REQ-031 Release and re-press:
  - Following REQ-029, BTN[0] goes low -> LEVEL[0] falls at edge 6, RELEASE[0] high 1 cycle, TOGGLE[0] stays 1.
  - Second clean press -> TOGGLE[0]=0.
REQ-032 Simultaneous: BTN=2'b11 on the same edge -> PRESS=2'b11 in the same single cycle, and LEVEL=2'b11.
REQ-033 Reset mid-count: BTN[0] high, RS_N low after edge 4 for 2 cycles -> all outputs 0 immediately; LEVEL[0] rises at post-reset edge 6.
REQ-034 BTN_TOGGLE_EN undefined, REQ-029 and REQ-031 stimulus -> TOGGLE=2'b00 constantly; LEVEL, PRESS and RELEASE unchanged from the defined case.
